// File: rtl/ram_sp_burst_master.sv
// ram_sp_burst_master: burst initiator for the single-port RAM.
// Turns burst commands plus write/read streams into one RAM access per word.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_write               1 = write burst, 0 = read burst
//   cmd_addr, cmd_len       start address, beats minus one
//   wdata_valid/ready, wdata   write word stream (ready only in WR)
//   rdata_valid/ready, rdata   read word stream, held until accepted
//   done                    1-cycle pulse at end of burst
//   cmd_err                 1-cycle pulse, out-of-range command dropped
//   mem_addr, mem_data      RAM address / data_in
//   mem_wr, mem_rd          RAM Wr / Rd strobes
//   mem_rdata               RAM combinational read data
module ram_sp_burst_master #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int MEMORY_DEPTH  = 1024,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     rdata_valid,
  input  logic                     rdata_ready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     done,
  output logic                     cmd_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_wr,
  output logic                     mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int LW = LEN_WIDTH;

  localparam logic [AW-1:0] LAST_ADDR =
    AW'(MEMORY_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP,
    RD_OUT
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [LW-1:0] cnt;

  logic [AW-1:0] addr_nxt;
  logic          cnt_zero;
  logic          addr_bad;

  // Wrap at the configured depth, which need
  // not be a power of two.
  assign addr_nxt = (addr == LAST_ADDR) ?
                    '0 : addr + 1'b1;

  assign cnt_zero = (cnt == '0);

  // Zero-extend so the range check still works
  // when the depth fills the whole address space.
  assign addr_bad =
    ({{(32-AW){1'b0}}, cmd_addr} >=
     32'(MEMORY_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      mem_wr  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr <= cmd_addr;
            cnt  <= cmd_len;
            if (addr_bad) begin
              cmd_err <= 1'b1;
            end else if (cmd_write) begin
              state       <= WR;
              cmd_ready   <= 1'b0;
              wdata_ready <= 1'b1;
            end else begin
              state     <= RD_ADDR;
              cmd_ready <= 1'b0;
            end
          end
        end

        WR: begin
          if (wdata_valid) begin
            mem_wr   <= 1'b1;
            mem_addr <= addr;
            mem_data <= wdata;
            if (cnt_zero) begin
              done        <= 1'b1;
              state       <= IDLE;
              wdata_ready <= 1'b0;
              cmd_ready   <= 1'b1;
            end else begin
              addr <= addr_nxt;
              cnt  <= cnt - 1'b1;
            end
          end
        end

        RD_ADDR: begin
          mem_rd   <= 1'b1;
          mem_addr <= addr;
          state    <= RD_CAP;
        end

        // RAM output has had a full cycle to
        // settle on the address set last edge.
        RD_CAP: begin
          rdata       <= mem_rdata;
          rdata_valid <= 1'b1;
          mem_rd      <= 1'b0;
          state       <= RD_OUT;
        end

        RD_OUT: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            if (cnt_zero) begin
              done      <= 1'b1;
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end else begin
              addr  <= addr_nxt;
              cnt   <= cnt - 1'b1;
              state <= RD_ADDR;
            end
          end
        end

        default: begin
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          wdata_ready <= 1'b0;
          rdata_valid <= 1'b0;
          mem_rd      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sp_burst_master.sv
// tb_ram_sp_burst_master: randomized directed bench.
// Shadow memory model plus a small-depth instance for range errors.
module tb_ram_sp_burst_master;

  localparam int DW     = 8;
  localparam int AW     = 10;
  localparam int LW     = 8;
  localparam int DEPTH  = 1024;
  localparam int SDEPTH = 768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready;
  logic [DW-1:0] rdata;
  logic          done, cmd_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr, mem_rd;
  logic [DW-1:0] mem_rdata;

  logic          s_cmd_valid, s_cmd_ready, s_cmd_write;
  logic [AW-1:0] s_cmd_addr;
  logic [LW-1:0] s_cmd_len;
  logic          s_wdata_valid, s_wdata_ready;
  logic [DW-1:0] s_wdata;
  logic          s_rdata_valid, s_rdata_ready;
  logic [DW-1:0] s_rdata;
  logic          s_done, s_cmd_err;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_data;
  logic          s_mem_wr, s_mem_rd;
  logic [DW-1:0] s_mem_rdata;

  ram_sp_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done), .cmd_err(cmd_err),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata)
  );

  ram_sp_burst_master #(.MEMORY_DEPTH(SDEPTH)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_write(s_cmd_write), .cmd_addr(s_cmd_addr),
    .cmd_len(s_cmd_len),
    .wdata_valid(s_wdata_valid),
    .wdata_ready(s_wdata_ready), .wdata(s_wdata),
    .rdata_valid(s_rdata_valid),
    .rdata_ready(s_rdata_ready), .rdata(s_rdata),
    .done(s_done), .cmd_err(s_cmd_err),
    .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .mem_wr(s_mem_wr), .mem_rd(s_mem_rd),
    .mem_rdata(s_mem_rdata)
  );

  // RAM environment: synchronous write, combinational read
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk)
    if (mem_wr) ram[mem_addr] <= mem_data;
  assign mem_rdata = ram[mem_addr];
  assign s_mem_rdata = 8'h5A;

  logic [DW-1:0] model [DEPTH];

  int checks = 0;
  int failures = 0;
  int both_cnt = 0;

  always @(negedge clk)
    if (mem_wr && mem_rd) both_cnt <= both_cnt + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_burst(input int a,
                          input int len,
                          input int gap_max,
                          input int stop_after);
    int n;
    n = len + 1;
    chk("wr_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(len);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g;
      int ea;
      logic [DW-1:0] d;
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int k = 0; k < g; k++) begin
        wdata_valid = 1'b0;
        wdata = 8'($urandom);
        tick();
        chk("wr_gap_idle", mem_wr, 0);
        chk("wr_gap_done", done, 0);
      end
      chk("wr_ready", wdata_ready, 1);
      d = 8'($urandom);
      wdata_valid = 1'b1;
      wdata = d;
      tick();
      wdata_valid = 1'b0;
      ea = (a + i) % DEPTH;
      model[ea] = d;
      chk("wr_pulse", mem_wr, 1);
      chk("wr_addr", mem_addr, ea);
      chk("wr_data", mem_data, d);
      chk("wr_done", done, (i == n - 1));
      chk("wr_no_rd", mem_rd, 0);
      if (i == stop_after) return;
    end
    chk("wr_end_ready", cmd_ready, 1);
    chk("wr_end_wready", wdata_ready, 0);
    tick();
    chk("wr_after_wr", mem_wr, 0);
    chk("wr_after_done", done, 0);
  endtask

  task automatic rd_burst(input int a,
                          input int len,
                          input int stall_beat,
                          input int stall_n,
                          input bit poke);
    int n;
    n = len + 1;
    chk("rd_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(len);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      int ea;
      ea = (a + i) % DEPTH;
      if (poke && i == 0) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = AW'($urandom);
        cmd_len   = LW'($urandom);
      end
      chk("rd_busy", cmd_ready, 0);
      chk("rd_pre_valid", rdata_valid, 0);
      chk("rd_pre_rd", mem_rd, 0);
      tick();
      chk("rd_cap_rd", mem_rd, 1);
      chk("rd_cap_addr", mem_addr, ea);
      chk("rd_cap_valid", rdata_valid, 0);
      chk("rd_cap_wr", mem_wr, 0);
      tick();
      cmd_valid = 1'b0;
      chk("rd_valid", rdata_valid, 1);
      chk("rd_data", rdata, model[ea]);
      chk("rd_out_rd", mem_rd, 0);
      if (i == stall_beat) begin
        for (int k = 0; k < stall_n; k++) begin
          tick();
          chk("rd_stall_valid", rdata_valid, 1);
          chk("rd_stall_data", rdata, model[ea]);
          chk("rd_stall_rd", mem_rd, 0);
          chk("rd_stall_done", done, 0);
        end
      end
      rdata_ready = 1'b1;
      tick();
      rdata_ready = 1'b0;
      chk("rd_hs_valid", rdata_valid, 0);
      chk("rd_done", done, (i == n - 1));
    end
    chk("rd_end_ready", cmd_ready, 1);
    tick();
    chk("rd_after_done", done, 0);
    chk("rd_after_rd", mem_rd, 0);
  endtask

  initial begin
    cmd_valid = 0; cmd_write = 0;
    cmd_addr = '0; cmd_len = '0;
    wdata_valid = 0; wdata = '0;
    rdata_ready = 0;
    s_cmd_valid = 0; s_cmd_write = 0;
    s_cmd_addr = '0; s_cmd_len = '0;
    s_wdata_valid = 0; s_wdata = '0;
    s_rdata_ready = 0;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wready", wdata_ready, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mdata", mem_data, 0);
    chk("rst_mwr", mem_wr, 0);
    chk("rst_mrd", mem_rd, 0);
    chk("rst_s_ready", s_cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    // reset mid write burst
    wr_burst(16'h100, 7, 0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mwr", mem_wr, 0);
    chk("arst_done", done, 0);
    chk("arst_rvalid", rdata_valid, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_wready", wdata_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_post_ready", cmd_ready, 1);

    // fill the whole memory with max-length bursts
    for (int b = 0; b < 4; b++)
      wr_burst(b * 256, 255, 0, -1);

    wr_burst(16'h3FE, 3, 0, -1);
    rd_burst(16'h3FE, 3, 2, 5, 1'b0);
    wr_burst($urandom_range(DEPTH - 1, 0), 2, 2, -1);
    rd_burst($urandom_range(DEPTH - 1, 0), 4, -1, 0, 1'b1);

    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(1, 0) == 1)
        wr_burst($urandom_range(DEPTH - 1, 0),
                 $urandom_range(6, 0),
                 $urandom_range(2, 0), -1);
      else
        rd_burst($urandom_range(DEPTH - 1, 0),
                 $urandom_range(6, 0),
                 $urandom_range(6, 0),
                 $urandom_range(3, 0),
                 1'($urandom_range(1, 0)));
    end

    rd_burst(16'h380, 255, -1, 0, 1'b0);

    // out-of-range commands on the 768-deep instance
    chk("s_ready0", s_cmd_ready, 1);
    s_cmd_valid = 1'b1;
    s_cmd_write = 1'b1;
    s_cmd_addr = 10'd768;
    s_cmd_len = 8'd3;
    tick();
    s_cmd_valid = 1'b0;
    chk("s_err_w", s_cmd_err, 1);
    chk("s_err_w_ready", s_cmd_ready, 1);
    chk("s_err_w_wready", s_wdata_ready, 0);
    chk("s_err_w_mwr", s_mem_wr, 0);
    tick();
    chk("s_err_pulse", s_cmd_err, 0);
    chk("s_err_idle_wr", s_mem_wr, 0);
    chk("s_err_idle_rd", s_mem_rd, 0);
    s_cmd_valid = 1'b1;
    s_cmd_write = 1'b0;
    s_cmd_addr = 10'd1023;
    tick();
    s_cmd_valid = 1'b0;
    chk("s_err_r", s_cmd_err, 1);
    chk("s_err_r_ready", s_cmd_ready, 1);
    tick();
    chk("s_err_r_mrd", s_mem_rd, 0);
    chk("s_err_r_valid", s_rdata_valid, 0);

    // wrap at depth-1 on the small instance
    s_cmd_valid = 1'b1;
    s_cmd_write = 1'b1;
    s_cmd_addr = 10'd767;
    s_cmd_len = 8'd1;
    tick();
    s_cmd_valid = 1'b0;
    chk("s_ok_err", s_cmd_err, 0);
    s_wdata_valid = 1'b1;
    s_wdata = 8'h3C;
    tick();
    chk("s_w0_wr", s_mem_wr, 1);
    chk("s_w0_addr", s_mem_addr, 767);
    chk("s_w0_done", s_done, 0);
    s_wdata = 8'hC3;
    tick();
    s_wdata_valid = 1'b0;
    chk("s_w1_addr", s_mem_addr, 0);
    chk("s_w1_data", s_mem_data, 8'hC3);
    chk("s_w1_done", s_done, 1);
    tick();

    chk("never_wr_and_rd", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
